// File: rtl/window_spill_fill_ctrl_pkg.sv
// window_spill_fill_ctrl_pkg: shared types, constants and window arithmetic for the spill/fill controller
package window_spill_fill_ctrl_pkg;
  localparam int NWIN = 4;
  localparam int WIN_REGS = 16;
  localparam int FIRST_WIN_REG = 16;
  localparam int WIN_BYTES = 64;
  localparam logic [NWIN-1:0] WIM_RST = 4'b0010;
  typedef logic [$clog2(NWIN)-1:0] win_t;
  typedef enum logic [2:0] {IDLE, SPILL_RD, SPILL_WR, FILL_REQ, FILL_WR, FINISH} state_t;
  function automatic win_t win_inc(input win_t w);
    return w + win_t'(1);
  endfunction
  function automatic win_t win_dec(input win_t w);
    return w - win_t'(1);
  endfunction
  function automatic logic [NWIN-1:0] onehot(input win_t w);
    return {{(NWIN-1){1'b0}}, 1'b1} << w;
  endfunction
  function automatic logic [31:0] slot_addr(input logic [31:0] base, input win_t w, input logic [3:0] idx);
    return base + 32'(w) * 32'(WIN_BYTES) + {26'd0, idx, 2'b00};
  endfunction
  function automatic logic [4:0] win_reg(input logic [3:0] idx);
    return 5'(FIRST_WIN_REG) + {1'b0, idx};
  endfunction
endpackage

// File: rtl/window_spill_fill_ctrl.sv
// window_spill_fill_ctrl: owns CWP/WIM and moves r16..r31 between register file and memory on window traps
module window_spill_fill_ctrl
  import window_spill_fill_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        save,
  input  logic        restore,
  input  logic        wr_cwp,
  input  logic [1:0]  cwp_in,
  input  logic        wr_wim,
  input  logic [3:0]  wim_in,
  input  logic [31:0] mem_base,
  output logic        busy,
  output logic        done,
  output logic [1:0]  cwp,
  output logic [3:0]  wim,
  output logic        rf_own,
  output logic [1:0]  rf_cwp,
  output logic [4:0]  rf_ra,
  input  logic [31:0] rf_aout,
  output logic [4:0]  rf_rc,
  output logic [31:0] rf_rin,
  output logic        rf_rfe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  state_t state;
  logic [3:0] cnt;
  logic [3:0] wim_nxt;
  win_t nwin, win, n;
  logic last;
  assign n = save ? win_dec(cwp) : win_inc(cwp);
  assign last = cnt == 4'(WIN_REGS - 1);
  assign rf_own = busy;
  // mem_wdata and rf_rin double as the transfer data register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cwp <= '0;
      wim <= WIM_RST;
      cnt <= '0;
      wim_nxt <= WIM_RST;
      nwin <= '0;
      win <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rf_cwp <= '0;
      rf_ra <= '0;
      rf_rc <= '0;
      rf_rin <= '0;
      rf_rfe <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      rf_rfe <= 1'b0;
      case (state)
        IDLE:
          if (save || restore) begin
            busy <= 1'b1;
            nwin <= n;
            cnt <= '0;
            if (!wim[n]) begin
              wim_nxt <= wim;
              done <= 1'b1;
              state <= FINISH;
            end else if (save) begin
              win <= win_dec(n);
              wim_nxt <= onehot(win_dec(n));
              rf_cwp <= win_dec(n);
              rf_ra <= win_reg(4'd0);
              state <= SPILL_RD;
            end else begin
              win <= n;
              wim_nxt <= onehot(win_inc(n));
              rf_cwp <= n;
              mem_req <= 1'b1;
              mem_addr <= slot_addr(mem_base, n, 4'd0);
              state <= FILL_REQ;
            end
          end else begin
            if (wr_cwp) cwp <= cwp_in;
            if (wr_wim) wim <= wim_in;
          end
        SPILL_RD: begin
          mem_req <= 1'b1;
          mem_we <= 1'b1;
          mem_addr <= slot_addr(mem_base, win, cnt);
          mem_wdata <= rf_aout;
          state <= SPILL_WR;
        end
        SPILL_WR:
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            cnt <= cnt + 4'd1;
            rf_ra <= win_reg(cnt + 4'd1);
            done <= last;
            state <= last ? FINISH : SPILL_RD;
          end
        FILL_REQ:
          if (mem_ack) begin
            mem_req <= 1'b0;
            rf_rc <= win_reg(cnt);
            rf_rin <= mem_rdata;
            rf_rfe <= 1'b1;
            state <= FILL_WR;
          end
        FILL_WR: begin
          cnt <= cnt + 4'd1;
          done <= last;
          mem_req <= !last;
          mem_addr <= slot_addr(mem_base, win, cnt + 4'd1);
          state <= last ? FINISH : FILL_REQ;
        end
        FINISH: begin
          cwp <= nwin;
          wim <= wim_nxt;
          busy <= 1'b0;
          cnt <= '0;
          rf_cwp <= '0;
          rf_ra <= '0;
          rf_rc <= '0;
          rf_rin <= '0;
          mem_addr <= '0;
          mem_wdata <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_window_spill_fill_ctrl.sv
// tb_window_spill_fill_ctrl: random SAVE/RESTORE traffic scored against a window/memory reference model
module tb_window_spill_fill_ctrl;
  logic clk = 0, rst_n = 0, save = 0, restore = 0, wr_cwp = 0, wr_wim = 0;
  logic [1:0] cwp_in = 0;
  logic [3:0] wim_in = 0;
  logic [31:0] mem_base = 0, mem_rdata = 0;
  logic mem_ack = 0;
  logic busy, done, rf_own, rf_rfe, mem_req, mem_we;
  logic [1:0] cwp, rf_cwp;
  logic [3:0] wim;
  logic [4:0] rf_ra, rf_rc;
  logic [31:0] rf_aout, rf_rin, mem_addr, mem_wdata;
  typedef struct {bit we; logic [31:0] a; logic [31:0] d;} mem_op_t;
  typedef struct {logic [1:0] w; logic [4:0] r; logic [31:0] d;} rf_op_t;
  mem_op_t exp_mem[$];
  rf_op_t exp_rf[$];
  logic [5:0] exp_done[$];
  mem_op_t me;
  rf_op_t re;
  logic [31:0] phys_rf [4][32];
  logic [31:0] ref_rf [4][32];
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [1:0] m_cwp = 0;
  logic [3:0] m_wim = 4'b0010;
  logic [5:0] pend_val = 0;
  logic [31:0] seed = 0;
  logic [31:0] bases [4] = '{32'h0000_1000, 32'h2000_0040, 32'hFFFF_FFF0, 32'h0000_0400};
  int total = 0, bad = 0, lat_mode = 1, cur_lat = 1, wcnt = 0, nwr = 0, ec = 0;
  bit noise = 0, pend = 0;

  always #5 clk = ~clk;

  window_spill_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .save(save), .restore(restore), .wr_cwp(wr_cwp), .cwp_in(cwp_in),
    .wr_wim(wr_wim), .wim_in(wim_in), .mem_base(mem_base), .busy(busy), .done(done), .cwp(cwp),
    .wim(wim), .rf_own(rf_own), .rf_cwp(rf_cwp), .rf_ra(rf_ra), .rf_aout(rf_aout), .rf_rc(rf_rc),
    .rf_rin(rf_rin), .rf_rfe(rf_rfe), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  assign rf_aout = phys_rf[rf_cwp][rf_ra];

  function automatic logic [31:0] rf_init(input int w, input int r);
    return (32'(w * 32 + r) * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic fail(input string name, input logic [127:0] got, input logic [127:0] exp);
    bad++;
    $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) fail(name, got, exp);
  endtask

  task automatic init_ref_rf();
    for (int w = 0; w < 4; w++)
      for (int r = 0; r < 32; r++) ref_rf[w][r] = rf_init(w, r);
  endtask

  task automatic set_lat(input int l);
    lat_mode = l;
    cur_lat = (l == 0) ? int'($urandom_range(1, 3)) : l;
  endtask

  // register file storage: reloads its known image while reset is held
  always @(posedge clk)
    if (!rst_n) begin
      for (int w = 0; w < 4; w++)
        for (int r = 0; r < 32; r++) phys_rf[w][r] <= rf_init(w, r);
    end else if (rf_rfe) phys_rf[rf_cwp][rf_rc] <= rf_rin;

  // memory responder and transaction monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 0;
      wcnt = 0;
    end else if (mem_req && !mem_ack) begin
      if (wcnt + 1 >= cur_lat) begin
        mem_ack = 1;
        wcnt = 0;
        if (exp_mem.size() == 0) begin
          total++;
          fail("unexpected_mem_req", {mem_we, mem_addr}, 0);
        end else begin
          me = exp_mem.pop_front();
          chk("mem_op", {mem_we, mem_addr, mem_we ? mem_wdata : 32'd0}, {me.we, me.a, me.we ? me.d : 32'd0});
        end
        if (mem_we) begin
          phys_mem[mem_addr] = mem_wdata;
          nwr++;
        end else mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : mem_default(mem_addr);
        cur_lat = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
      end else wcnt++;
    end else mem_ack = (!mem_req && noise) ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  always @(negedge clk)
    if (rf_rfe) begin
      if (exp_rf.size() == 0) begin
        total++;
        fail("unexpected_rf_write", {rf_cwp, rf_rc, rf_rin}, 0);
      end else begin
        re = exp_rf.pop_front();
        chk("rf_write", {rf_cwp, rf_rc, rf_rin}, {re.w, re.r, re.d});
      end
    end

  always @(negedge clk) begin
    if (pend) begin
      chk("final_cwp_wim", {busy, cwp, wim}, {1'b0, pend_val});
      pend = 0;
    end
    if (done && rst_n) begin
      if (exp_done.size() == 0) begin
        total++;
        fail("unexpected_done", {cwp, wim}, 0);
      end else begin
        pend_val = exp_done.pop_front();
        pend = 1;
      end
    end
  end

  // reference model: window rules applied at issue time, expected traffic queued
  task automatic issue(input bit s, input bit r, input bit wc, input logic [1:0] ci, input bit ww,
                       input logic [3:0] wi, input logic [31:0] base, output int exp_cyc);
    logic [1:0] n, v;
    logic [3:0] nw;
    logic [31:0] a, d;
    exp_cyc = 0;
    save = s; restore = r; wr_cwp = wc; cwp_in = ci; wr_wim = ww; wim_in = wi; mem_base = base;
    if (s || r) begin
      n = 2'((m_cwp + (s ? 3 : 1)) % 4);
      if (m_wim[n]) begin
        v = s ? 2'((n + 3) % 4) : n;
        for (int i = 0; i < 16; i++) begin
          a = base + 32'(v) * 32'd64 + 32'(i) * 32'd4;
          if (s) begin
            exp_mem.push_back('{1'b1, a, ref_rf[v][16+i]});
            ref_mem[a] = ref_rf[v][16+i];
          end else begin
            d = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
            exp_mem.push_back('{1'b0, a, 32'd0});
            exp_rf.push_back('{v, 5'(16 + i), d});
            ref_rf[v][16+i] = d;
          end
        end
        nw = s ? 4'(1 << v) : 4'(1 << ((n + 1) % 4));
        exp_cyc = (lat_mode == 0) ? 0 : 16 * (lat_mode + 1) + 1;
      end else begin
        nw = m_wim;
        exp_cyc = 1;
      end
      exp_done.push_back({n, nw});
      m_cwp = n;
      m_wim = nw;
    end else begin
      if (wc) m_cwp = ci;
      if (ww) m_wim = wi;
    end
    @(posedge clk);
    #1;
    save = 0; restore = 0; wr_cwp = 0; wr_wim = 0;
  endtask

  task automatic wait_done(input int exp_cyc);
    int got = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (done) begin
        got = c;
        break;
      end
    end
    if (got == 0) begin
      total++;
      fail("done_timeout", 0, 1);
    end else if (exp_cyc > 0) chk("op_cycles", got, exp_cyc);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1;
        break;
      end
    end
    if (!idle) begin
      total++;
      fail("idle_timeout", 1, 0);
    end
    chk("idle_outputs", {rf_own, rf_cwp, rf_ra, rf_rc, rf_rin, rf_rfe, mem_req, mem_we, mem_addr, mem_wdata, done}, 0);
  endtask

  task automatic run(input bit s, input bit r, input bit wc, input logic [1:0] ci, input bit ww,
                     input logic [3:0] wi, input logic [31:0] base);
    int e;
    issue(s, r, wc, ci, ww, wi, base, e);
    if (s || r) wait_done(e);
    else begin
      @(negedge clk);
      chk("reg_load", {cwp, wim}, {m_cwp, m_wim});
    end
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = $urandom;
    init_ref_rf();
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, rf_own, cwp, wim, mem_req, mem_we, rf_rfe, mem_addr, rf_ra, rf_rin},
        {3'b000, 2'd0, 4'b0010, 3'b000, 32'd0, 5'd0, 32'd0});
    rst_n = 1;
    set_lat(1);
    run(1, 0, 0, 0, 0, 0, bases[0]);
    chk("save1_cwp", cwp, 3);
    run(1, 0, 0, 0, 0, 0, bases[0]);
    run(1, 0, 0, 0, 0, 0, bases[0]);
    chk("spill_l1_state", {cwp, wim}, {2'd1, 4'b0001});
    run(0, 0, 1, 2'd2, 1, 4'b0010, 0);
    set_lat(3);
    run(1, 0, 0, 0, 0, 0, bases[0]);
    set_lat(1);
    run(0, 1, 0, 0, 0, 0, bases[0]);
    run(0, 1, 0, 0, 0, 0, bases[0]);
    run(0, 1, 0, 0, 0, 0, bases[0]);
    chk("fill_state", {cwp, wim}, {2'd0, 4'b0010});
    run(1, 1, 1, 2'd1, 1, 4'hF, bases[0]);
    chk("save_wins", {cwp, wim}, {2'd3, 4'b0010});
    run(0, 0, 1, 2'd2, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, bases[0], ec);
    repeat (3) @(negedge clk);
    save = 1; restore = 1; wr_cwp = 1; cwp_in = 0; wr_wim = 1; wim_in = 4'hF;
    @(negedge clk);
    save = 0; restore = 0; wr_cwp = 0; wr_wim = 0;
    wait_done(ec - 4);
    wait_idle();
    run(0, 0, 1, 2'd1, 1, 4'b0001, 0);
    run(1, 0, 0, 0, 0, 0, 32'hFFFF_FFF0);
    chk("wrap_first_slot", phys_mem.exists(32'h0000_00B0) ? phys_mem[32'h0000_00B0] : 32'd0, ref_rf[3][16]);
    noise = 1;
    set_lat(0);
    for (int it = 0; it < 40; it++) begin
      int k;
      k = $urandom_range(0, 9);
      run(k < 4, k >= 3 && k < 7, ($urandom_range(0, 2) == 0) || k >= 7, 2'($urandom), ($urandom_range(0, 2) == 0) || k >= 8,
          4'($urandom), bases[$urandom_range(0, 3)]);
    end
    noise = 0;
    set_lat(3);
    run(0, 0, 1, 2'd2, 1, 4'b0110, 0);
    nwr = 0;
    issue(1, 0, 0, 0, 0, 0, 32'h8000_0000, ec);
    for (int c = 0; c < 400 && nwr < 5; c++) @(negedge clk);
    if (nwr < 5) begin
      total++;
      fail("abort_wait_timeout", nwr, 5);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    #1;
    chk("req_before_abort", mem_req, 1);
    rst_n = 0;
    #1;
    chk("abort_req_drop", mem_req, 0);
    chk("abort_state", {busy, done, cwp, wim}, {2'b00, 2'd0, 4'b0010});
    exp_mem.delete();
    exp_rf.delete();
    exp_done.delete();
    m_cwp = 0;
    m_wim = 4'b0010;
    init_ref_rf();
    repeat (2) @(negedge clk);
    rst_n = 1;
    set_lat(1);
    run(0, 1, 0, 0, 0, 0, bases[0]);
    run(1, 0, 0, 0, 0, 0, bases[0]);
    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("rf_queue_drained", exp_rf.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
